md_sched: RTL and testbench
===========================

# md_sched

Sequencing controller for the shared multiply/divide unit in the 5-stage pipeline. It sits beside the DX stage and detects `mul` and `div` instructions, which are R-type with opcode 00000 and ALU op 00110 or 00111. For each one it launches a single operation on the iterative multdiv unit and holds PC/FD/DX frozen until the result is back. It then hands the result, or the rstatus exception value, to the XM-stage input mux for one cycle.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 40: maximum WAIT cycles before the operation is forcibly ended; range 2..255.
- `RSTATUS_MUL`, default 32'd4: value written on a mul exception.
- `RSTATUS_DIV`, default 32'd5: value written on a div exception.

Ports:
- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-low.
- `dx_valid`  in  1: DX holds a real instruction, not a bubble.
- `dx_opcode`  in  5: DX instruction [31:27].
- `dx_aluop`  in  5: DX instruction [6:2].
- `dx_rd`  in  5: DX instruction [26:22].
- `dx_a`, `dx_b`  in  32: bypassed operands for the DX instruction.
- `ctrl_MULT`, `ctrl_DIV`  out  1: one-cycle start pulses to multdiv.
- `md_operand_a`, `md_operand_b`  out  32: latched operands, held stable from START through DONE.
- `md_result`  in  32: multdiv `data_result`.
- `md_exception`  in  1: multdiv `data_exception`.
- `md_ready`  in  1: multdiv `data_resultRDY`.
- `stall`  out  1: freeze PC, FD and DX.
- `res_valid`  out  1: one-cycle flag; XM takes `res_data` in place of the ALU output.
- `res_data`  out  32: result value.
- `res_rd`  out  5: writeback register.
- `res_exc`  out  1: sets the XM overflow/exception bit.
- `timeout`  out  1: one-cycle pulse when the watchdog fires.
- `busy`  out  1: FSM not in IDLE.

## Operation
- State register has four states: IDLE, START, WAIT, DONE. An 8-bit `cnt` register and latched `op_is_div`, `rd`, operands, result and exception hold the operation context.
- Detect signal: `md_hit = dx_valid & dx_opcode==0 & (dx_aluop==00110 | dx_aluop==00111)`.
- IDLE:
  - On `md_hit`, latch `dx_a`, `dx_b`, `dx_rd` and op type, then go to START.
  - Otherwise stay in IDLE.
- START:
  - Assert `ctrl_MULT` if the op is mul, or `ctrl_DIV` if it is div, for exactly this cycle.
  - Clear `cnt` and go to WAIT.
  - `md_ready` is ignored in this state.
- WAIT, evaluated in this order:
  - If `md_ready`: capture `md_result` and `md_exception`, go to DONE.
  - Else if `cnt == TIMEOUT_CYCLES-1`: force exception=1, pulse `timeout`, go to DONE.
  - Else: increment `cnt`.
  - If `md_ready` arrives on the same cycle as the limit, the ready path wins and `timeout` is not pulsed.
- DONE:
  - Assert `res_valid` and return to IDLE.
  - `stall` is low in this state, so the mul/div instruction leaves DX on this edge.
  - A new `md_hit` is not evaluated until the next cycle. The instruction that follows is judged in IDLE.
- Outputs, all combinational from state:
  - `stall = (IDLE & md_hit) | START | WAIT`.
  - `res_data = exc ? (op_is_div ? RSTATUS_DIV : RSTATUS_MUL) : captured result`.
  - `res_rd = exc ? 5'd30 : rd`.
  - `res_exc = exc`.
  - `busy = state != IDLE`.
  - `res_data`, `res_rd` and `res_exc` are qualified by `res_valid` only. Their values outside DONE are don't-care but must be deterministic.
- Divide by zero is reported by multdiv via `md_exception` and is handled the same as any other exception.
- Non-mul/div instructions never cause a stall and never pulse the start lines.

## Timing
- Reset asserted, asynchronously: state goes to IDLE, `cnt` to 0, all latches to 0. Every output is 0, except `stall`, which follows `IDLE & md_hit` combinationally. Any in-flight operation is abandoned with no result pulse.
- Release of reset is synchronous to the next rising edge.
- Cycle timing for an op detected at cycle 0 (IDLE):
  - Cycle 1: START, start pulse.
  - Cycle 2 onward: WAIT.
  - If `md_ready` is high at cycle k ≥ 2, DONE and `res_valid` occur at cycle k+1.
- `stall` is high for cycles 0..k inclusive, which is k+1 cycles.
- Worst case: `res_valid` is at cycle `TIMEOUT_CYCLES+2`.
- Back-to-back mul/div instructions get a minimum gap of one IDLE cycle between a DONE and the next START.
- Exactly one start pulse is issued per detected instruction.

## Test plan
- **mul:** mul r3 = 7 × 6, model returns `md_ready` 32 cycles after the pulse.
  - One `ctrl_MULT` pulse at cycle 1, and `ctrl_DIV` stays 0.
  - `stall` is high for cycles 0..33.
  - `res_valid` at cycle 34 with `res_data`=42, `res_rd`=3, `res_exc`=0.
- **div by zero:** div r5 = 100 / 0, model returns `md_exception`=1.
  - `res_rd`=30, `res_data`=5, `res_exc`=1.
- **mul overflow:** mul with `md_exception`=1 → `res_rd`=30, `res_data`=4.
- **timeout:** div with `md_ready` never asserted, `TIMEOUT_CYCLES`=40.
  - `timeout` pulses at cycle 41 (WAIT, `cnt`=39).
  - `res_valid` at cycle 42 with `res_data`=5, `res_rd`=30.
- **back-to-back:** mul then div in consecutive DX slots.
  - Two separate pulses (`ctrl_MULT`, then `ctrl_DIV`) and two `res_valid` pulses.
  - The second start pulse comes exactly two cycles after the first `res_valid`.
- **reset and non-mul/div traffic:**
  - `reset` driven low mid-WAIT: all outputs 0 immediately and no `res_valid`; after release, a new mul completes normally.
  - A stream of add/lw instructions never raises `stall`.

Source files
------------

// File: rtl/md_sched.sv
// md_sched: sequencing controller for the shared iterative multiply/divide unit.
// It spots mul/div in DX and launches one multdiv operation for each. While the
// operation runs it freezes PC/FD/DX. It then presents the result, or the
// rstatus exception value, to the XM input mux for exactly one cycle.
module md_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter logic [31:0] RSTATUS_MUL    = 32'd4,
  parameter logic [31:0] RSTATUS_DIV    = 32'd5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dx_valid,
  input  logic [4:0]  dx_opcode,
  input  logic [4:0]  dx_aluop,
  input  logic [4:0]  dx_rd,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_operand_a,
  output logic [31:0] md_operand_b,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        stall,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_exc,
  output logic        timeout,
  output logic        busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [4:0] AluMul  = 5'b00110;
  localparam logic [4:0] AluDiv  = 5'b00111;
  localparam logic [4:0] ExcReg  = 5'd30;
  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic md_hit;
  logic wd_fire;

  // Decode a real mul/div sitting in DX; aluop bit 0 distinguishes div from mul.
  always_comb begin
    md_hit = dx_valid & (dx_opcode == 5'd0) & ((dx_aluop == AluMul) | (dx_aluop == AluDiv));
  end

  // Watchdog fires only on the last WAIT cycle and only if multdiv is not ready then.
  always_comb begin
    wd_fire = (state_q == StWait) & ~md_ready & (cnt_q == CntLast);
  end

  // Next-state and operation-context updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    rd_d     = rd_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    exc_d    = exc_q;
    unique case (state_q)
      StIdle: begin
        if (md_hit) begin
          a_d     = dx_a;
          b_d     = dx_b;
          rd_d    = dx_rd;
          div_d   = dx_aluop[0];
          state_d = StStart;
        end
      end
      StStart: begin
        // md_ready is deliberately ignored here; the start pulse is in flight.
        cnt_d   = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        if (md_ready) begin
          result_d = md_result;
          exc_d    = md_exception;
          state_d  = StDone;
        end else if (wd_fire) begin
          exc_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone: begin
        // The mul/div leaves DX on this edge; the next instruction is judged in IDLE.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and context registers; reset abandons any in-flight operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      div_q    <= 1'b0;
      rd_q     <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  // Outputs decoded from state plus the latched context.
  always_comb begin
    ctrl_MULT    = (state_q == StStart) & ~div_q;
    ctrl_DIV     = (state_q == StStart) & div_q;
    md_operand_a = a_q;
    md_operand_b = b_q;
    stall        = ((state_q == StIdle) & md_hit) | (state_q == StStart) | (state_q == StWait);
    res_valid    = (state_q == StDone);
    res_exc      = exc_q;
    res_rd       = exc_q ? ExcReg : rd_q;
    res_data     = exc_q ? (div_q ? RSTATUS_DIV : RSTATUS_MUL) : result_q;
    timeout      = wd_fire;
    busy         = (state_q != StIdle);
  end

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: scoreboard bench for md_sched. A driver feeds a DX instruction
// stream that advances only when stall is low, and plays the multdiv unit.
// A negedge monitor pops the expected results and compares them.
module tb_md_sched;

  localparam int unsigned TMO   = 40;
  localparam int          NEVER = 1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        dx_valid;
  logic [4:0]  dx_opcode, dx_aluop, dx_rd;
  logic [31:0] dx_a, dx_b;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] md_operand_a, md_operand_b;
  logic [31:0] md_result;
  logic        md_exception, md_ready;
  logic        stall, res_valid, res_exc, timeout, busy;
  logic [31:0] res_data;
  logic [4:0]  res_rd;

  always #5 clock = ~clock;

  md_sched #(.TIMEOUT_CYCLES(TMO), .RSTATUS_MUL(32'd4), .RSTATUS_DIV(32'd5)) dut (
    .clock       (clock),
    .reset       (reset),
    .dx_valid    (dx_valid),
    .dx_opcode   (dx_opcode),
    .dx_aluop    (dx_aluop),
    .dx_rd       (dx_rd),
    .dx_a        (dx_a),
    .dx_b        (dx_b),
    .ctrl_MULT   (ctrl_MULT),
    .ctrl_DIV    (ctrl_DIV),
    .md_operand_a(md_operand_a),
    .md_operand_b(md_operand_b),
    .md_result   (md_result),
    .md_exception(md_exception),
    .md_ready    (md_ready),
    .stall       (stall),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .res_exc     (res_exc),
    .timeout     (timeout),
    .busy        (busy)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  op;
    logic [4:0]  alu;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;   // multdiv latency after the start pulse; NEVER = no answer
    logic        exc;
    logic [31:0] res;
  } instr_t;

  typedef struct {
    logic        is_div;
    int          load_cyc;
    logic [31:0] a;
    logic [31:0] b;
  } start_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
    logic        tmo;
    int          wait_cyc;
  } exp_t;

  instr_t prog[$];
  start_t start_q[$];
  exp_t   exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic instr_t mk_md(input logic is_div, input logic [4:0] rd,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input int lat, input logic exc);
    instr_t i;
    i.valid = 1'b1;
    i.op    = 5'd0;
    i.alu   = is_div ? 5'b00111 : 5'b00110;
    i.rd    = rd;
    i.a     = a;
    i.b     = b;
    i.lat   = lat;
    if (is_div) begin
      i.exc = exc | (b == 32'd0);
      i.res = (b == 32'd0) ? 32'hffff_ffff : a / b;
    end else begin
      i.exc = exc;
      i.res = a * b;
    end
    return i;
  endfunction

  function automatic instr_t mk_other(input int kind);
    instr_t i;
    i.valid = 1'b1;
    i.op    = 5'd0;
    i.alu   = 5'd0;
    i.rd    = 5'($urandom_range(0, 31));
    i.a     = $urandom;
    i.b     = $urandom;
    i.lat   = 0;
    i.exc   = 1'b0;
    i.res   = 32'd0;
    case (kind)
      1: begin i.op = 5'b01000; i.alu = 5'($urandom_range(0, 31)); end  // lw
      2: begin i.valid = 1'b0; i.alu = 5'b00110; end                    // bubble that looks like mul
      3: i.alu = 5'b00101;                                              // neighbour ALU op
      default: i.alu = 5'd0;                                            // add
    endcase
    return i;
  endfunction

  // ---------------- driver / multdiv model ----------------
  logic        dx_md_tb  = 1'b0;
  logic        md_active = 1'b0;
  int          md_cd     = 0;
  int          cur_lat   = 0;
  logic        cur_exc   = 1'b0;
  logic [31:0] cur_res   = 32'd0;

  task automatic load_next();
    instr_t i;
    start_t s;
    exp_t   e;
    logic   md;
    if (prog.size() == 0) begin
      dx_valid = 1'b0; dx_opcode = 5'd0; dx_aluop = 5'd0; dx_rd = 5'd0;
      dx_a = 32'd0; dx_b = 32'd0; dx_md_tb = 1'b0;
      return;
    end
    i = prog.pop_front();
    dx_valid = i.valid; dx_opcode = i.op; dx_aluop = i.alu; dx_rd = i.rd;
    dx_a = i.a; dx_b = i.b;
    md = i.valid && (i.op == 5'd0) && ((i.alu == 5'b00110) || (i.alu == 5'b00111));
    dx_md_tb = md;
    if (md) begin
      cur_lat = i.lat; cur_exc = i.exc; cur_res = i.res;
      s.is_div = (i.alu == 5'b00111); s.load_cyc = cyc; s.a = i.a; s.b = i.b;
      start_q.push_back(s);
      e.tmo      = (i.lat > int'(TMO));
      e.wait_cyc = e.tmo ? int'(TMO) : i.lat;
      e.exc      = e.tmo | i.exc;
      e.rd       = e.exc ? 5'd30 : i.rd;
      e.data     = e.exc ? (s.is_div ? 32'd5 : 32'd4) : i.res;
      exp_q.push_back(e);
    end
  endtask

  // One clock: observe at negedge, update inputs just after the rising edge.
  task automatic step();
    logic s, p, rv;
    @(negedge clock);
    s  = stall;
    p  = ctrl_MULT | ctrl_DIV;
    rv = res_valid;
    @(posedge clock);
    #1;
    if (rv) md_active = 1'b0;
    if (p) begin md_active = 1'b1; md_cd = cur_lat; end
    md_ready = 1'b0; md_exception = 1'b0; md_result = $urandom;
    if (md_active) begin
      md_cd--;
      if (md_cd == 0) begin
        md_ready = 1'b1; md_result = cur_res; md_exception = cur_exc; md_active = 1'b0;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      md_ready = 1'b1;                 // stray ready outside WAIT must be ignored
      md_exception = 1'($urandom_range(0, 1));
    end
    if (!s) load_next();
  endtask

  task automatic drain();
    int guard = 0;
    while ((prog.size() != 0 || start_q.size() != 0 || exp_q.size() != 0) && guard < 5000) begin
      step();
      guard++;
    end
    chk("drain_budget", 32'(guard < 5000), 32'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic   prev_tmo  = 1'b0;
  int     run       = 0;
  int     start_cyc = 0;
  start_t ms;
  exp_t   me;

  always @(negedge clock) begin
    if (!reset) begin
      run = 0;
      prev_tmo = 1'b0;
    end else begin
      if (ctrl_MULT || ctrl_DIV) begin
        chk("start_exclusive", 32'(ctrl_MULT & ctrl_DIV), 32'd0);
        if (start_q.size() == 0) begin
          chk("unexpected_start", 32'd1, 32'd0);
        end else begin
          ms = start_q.pop_front();
          chk("start_is_div", 32'(ctrl_DIV), 32'(ms.is_div));
          chk("start_cycle", 32'(cyc), 32'(ms.load_cyc + 1));
          chk("operand_a", md_operand_a, ms.a);
          chk("operand_b", md_operand_b, ms.b);
          start_cyc = cyc;
        end
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_res_valid", 32'd1, 32'd0);
        end else begin
          me = exp_q.pop_front();
          chk("res_data", res_data, me.data);
          chk("res_rd", 32'(res_rd), 32'(me.rd));
          chk("res_exc", 32'(res_exc), 32'(me.exc));
          chk("timeout_pulse", 32'(prev_tmo), 32'(me.tmo));
          chk("stall_cycles", 32'(run), 32'(me.wait_cyc + 2));
          chk("result_latency", 32'(cyc - start_cyc), 32'(me.wait_cyc + 1));
          chk("stall_in_done", 32'(stall), 32'd0);
        end
        run = 0;
      end else if (stall) begin
        run++;
      end
      if (!dx_md_tb) begin
        chk("stall_non_md", 32'(stall), 32'd0);
        chk("busy_non_md", 32'(busy), 32'd0);
      end
      prev_tmo = timeout;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0;
    dx_valid = 1'b0; dx_opcode = 5'd0; dx_aluop = 5'd0; dx_rd = 5'd0;
    dx_a = 32'd0; dx_b = 32'd0;
    md_result = 32'd0; md_exception = 1'b0; md_ready = 1'b0;
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_rd", 32'(res_rd), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Directed: plain mul, div by zero, mul overflow, timeout, limit boundary.
    prog.push_back(mk_md(1'b0, 5'd3, 32'd7, 32'd6, 32, 1'b0));
    prog.push_back(mk_md(1'b1, 5'd5, 32'd100, 32'd0, 20, 1'b0));
    prog.push_back(mk_md(1'b0, 5'd7, 32'h8000_0000, 32'd4, 10, 1'b1));
    prog.push_back(mk_md(1'b1, 5'd9, 32'd50, 32'd5, NEVER, 1'b0));
    prog.push_back(mk_md(1'b0, 5'd4, 32'd9, 32'd9, int'(TMO), 1'b0));      // ready on last WAIT
    prog.push_back(mk_md(1'b1, 5'd6, 32'd90, 32'd9, int'(TMO) + 1, 1'b0)); // one cycle too late
    prog.push_back(mk_md(1'b0, 5'd8, 32'd3, 32'd5, 1, 1'b0));              // fastest answer
    // Back-to-back mul then div in consecutive DX slots.
    prog.push_back(mk_md(1'b0, 5'd10, 32'd12, 32'd12, 5, 1'b0));
    prog.push_back(mk_md(1'b1, 5'd11, 32'd144, 32'd12, 7, 1'b0));
    // Non-mul/div traffic.
    for (int k = 0; k < 24; k++) prog.push_back(mk_other(k % 4));
    drain();

    // Randomized mix.
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        prog.push_back(mk_md(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                             ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                             ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(1, 45)),
                             ($urandom_range(0, 9) == 0)));
      end else begin
        prog.push_back(mk_other(int'($urandom_range(0, 3))));
      end
    end
    drain();

    // Reset mid-WAIT abandons the operation without a result pulse.
    prog.push_back(mk_md(1'b0, 5'd11, 32'd3, 32'd9, NEVER, 1'b0));
    for (int k = 0; k < 12; k++) step();
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    chk("midrst_operand_a", md_operand_a, 32'd0);
    chk("midrst_res_data", res_data, 32'd0);
    chk("midrst_res_rd", 32'(res_rd), 32'd0);
    chk("midrst_stall_hit", 32'(stall), 32'd1);  // mul still in DX, FSM in IDLE
    dx_valid = 1'b0;
    dx_md_tb = 1'b0;
    #1;
    chk("midrst_stall_bubble", 32'(stall), 32'd0);
    exp_q.delete();
    start_q.delete();
    md_active = 1'b0;
    md_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    prog.push_back(mk_md(1'b0, 5'd12, 32'd11, 32'd13, 6, 1'b0));
    drain();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
